// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and width helpers for the mux scan sequencer.
package scan_pkg;

    // FSM state encoding (kept as plain constants for legacy compatibility)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Default configuration and the widths it implies
    localparam int INS_DEF   = 6;
    localparam int DWELL_DEF = 4;
    localparam int SEL_W     = $clog2(INS_DEF);
    localparam int DW_W      = (DWELL_DEF > 1) ? $clog2(DWELL_DEF) : 1;

    // Select width for an arbitrary channel count (INS >= 2)
    function automatic int sel_width(input int ins);
        return $clog2(ins);
    endfunction

    // Dwell counter width; a single-cycle dwell still needs one bit
    function automatic int dw_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// dwell_counter: mod-DWELL cycle counter. tc marks the last cycle of a dwell
// window; the counter wraps to 0 on that same edge.
module dwell_counter
    import scan_pkg::*;
#(
    parameter int DWELL = DWELL_DEF,
    parameter int W     = dw_width(DWELL)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == W'(DWELL - 1));

    // Count while enabled, wrap at terminal count, hold at 0 while cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the select of an upstream 1-bit mux across all
// channels, holds each select for DWELL cycles, then samples f_in into a
// parallel capture word. Optional macro SCAN_CONTINUOUS_EN turns start into a
// level enable that chains passes back to back without an IDLE/DONE gap.
module mux_scan_sequencer
    import scan_pkg::*;
#(
    parameter int INS   = INS_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   f_in,
    output logic [$clog2(INS)-1:0] sel,
    output logic                   busy,
    output logic                   sample_valid,
    output logic                   sample_bit,
    output logic [$clog2(INS)-1:0] sample_idx,
    output logic [INS-1:0]         capture,
    output logic                   done
);

    localparam int S_W = sel_width(INS);
    localparam int C_W = dw_width(DWELL);
    localparam logic [S_W-1:0] LAST_SEL = S_W'(INS - 1);

    logic [1:0] state;
    logic       scanning;
    logic       tc;
    logic       last;

    assign scanning = (state == SCAN);
    assign busy     = scanning;
    // Sample edge of the final channel closes a pass
    assign last     = tc && (sel == LAST_SEL);

    dwell_counter #(
        .DWELL (DWELL),
        .W     (C_W)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!scanning),
        .en      (scanning),
        .tc      (tc)
    );

    // Pass sequencing: IDLE waits for start, SCAN steps sel per dwell, DONE is one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sel <= '0;
                    if (start) state <= SCAN;
                end
                SCAN: begin
                    if (tc) begin
                        if (sel == LAST_SEL) begin
`ifdef SCAN_CONTINUOUS_EN
                            // Chain straight into the next pass while enabled
                            if (start) sel <= '0;
                            else       state <= DONE;
`else
                            // sel parks on the last valid code, never wraps past it
                            state <= DONE;
`endif
                        end else begin
                            sel <= sel + S_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    sel   <= '0;
                end
                default: begin
                    state <= IDLE;
                    sel   <= '0;
                end
            endcase
        end
    end

    // Sample registers and pass-complete pulse; all loaded only on sample edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_valid <= 1'b0;
            sample_bit   <= 1'b0;
            sample_idx   <= '0;
            done         <= 1'b0;
        end else begin
            sample_valid <= tc;
            done         <= last;
            if (tc) begin
                sample_bit <= f_in;
                sample_idx <= sel;
            end
        end
    end

    // Capture word: each bit touched only at its own channel's sample edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            for (int k = 0; k < INS; k++) begin
                if (tc && (sel == S_W'(k))) capture[k] <= f_in;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed bench for the mux scan sequencer. Two
// instances: INS=6/DWELL=4 and INS=5/DWELL=1, each fed by a mux model.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start, start5;
    logic [5:0] w;
    logic [4:0] w5;

    logic       f_in, f5;
    logic [2:0] sel, sidx, sel5, sidx5;
    logic       busy, sv, sbit, done;
    logic       busy5, sv5, sbit5, done5;
    logic [5:0] cap;
    logic [4:0] cap5;

    // Mux models closing the loop sel -> f_in
    assign f_in = w[sel];
    assign f5   = w5[sel5];

    mux_scan_sequencer #(.INS(6), .DWELL(4)) u6 (
        .clk(clk), .reset_n(reset_n), .start(start), .f_in(f_in),
        .sel(sel), .busy(busy), .sample_valid(sv), .sample_bit(sbit),
        .sample_idx(sidx), .capture(cap), .done(done)
    );

    mux_scan_sequencer #(.INS(5), .DWELL(1)) u5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .f_in(f5),
        .sel(sel5), .busy(busy5), .sample_valid(sv5), .sample_bit(sbit5),
        .sample_idx(sidx5), .capture(cap5), .done(done5)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero6(input string tag);
        chk({tag, ".sel"},  sel,  0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".sv"},   sv,   0);
        chk({tag, ".sbit"}, sbit, 0);
        chk({tag, ".sidx"}, sidx, 0);
        chk({tag, ".cap"},  cap,  0);
        chk({tag, ".done"}, done, 0);
    endtask

    // Called just after edge E0; walks edges E0+1..E0+24 of a 6x4 pass
    task automatic pass6(input logic [5:0] wv, input bit repulse);
        for (int n = 1; n <= 24; n++) begin
            tick();
            if (repulse && n == 9)  start = 1'b1;
            if (repulse && n == 10) start = 1'b0;
            chk("p6.sel",  sel,  (n < 24) ? n / 4 : 5);
            chk("p6.sv",   sv,   (n % 4 == 0));
            chk("p6.busy", busy, (n < 24));
            chk("p6.done", done, (n == 24));
            if (n % 4 == 0) begin
                chk("p6.sidx", sidx, n / 4 - 1);
                chk("p6.sbit", sbit, wv[n/4-1]);
            end
        end
        chk("p6.cap", cap, wv);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        start5  = 1'b0;
        w       = 6'b111111;
        w5      = 5'b11111;

        // Reset: outputs held at 0 even with start and f_in high
        tick();
        chk_zero6("rst0");
        start = 1'b1;
        repeat (3) tick();
        chk_zero6("rst_start");
        chk("rst.busy5", busy5, 0);
        chk("rst.cap5",  cap5,  0);
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        chk_zero6("idle");

        // Single pass with w = 101101
        w = 6'b101101;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1.busy0", busy, 1);
        chk("t1.sel0",  sel,  0);
        pass6(w, 1'b0);
        tick();
        chk("t1.idle.busy", busy, 0);
        chk("t1.idle.done", done, 0);
        chk("t1.idle.sel",  sel,  0);

        // Start re-pulsed mid-scan is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        pass6(w, 1'b1);
        tick();
        chk("t2.idle.busy", busy, 0);

`ifndef SCAN_CONTINUOUS_EN
        // Start held high: next pass accepted at E0+26
        start = 1'b1;
        tick();
        pass6(w, 1'b0);
        tick();
        chk("hold.e25.busy", busy, 0);
        chk("hold.e25.sel",  sel,  0);
        chk("hold.e25.done", done, 0);
        tick();
        chk("hold.e26.busy", busy, 1);
        chk("hold.e26.sel",  sel,  0);
        start = 1'b0;
        pass6(w, 1'b0);
        tick();
        chk("hold.end.busy", busy, 0);
`else
        // Continuous: back-to-back passes, start dropped at E0+30
        w = 6'b111000;
        start = 1'b1;
        tick();
        for (int n = 1; n <= 48; n++) begin
            tick();
            if (n == 29) start = 1'b0;
            chk("cont.done", done, (n == 24 || n == 48));
            chk("cont.busy", busy, (n < 48));
            if (n == 20) chk("cont.sel5", sel, 5);
            if (n == 24) begin
                chk("cont.wrap", sel, 0);
                chk("cont.cap1", cap, 6'b111000);
            end
            if (n == 48) begin
                chk("cont.park", sel, 5);
                chk("cont.cap2", cap, 6'b111000);
            end
        end
        tick();
        chk("cont.idle.busy", busy, 0);
        chk("cont.idle.sel",  sel,  0);
        w = 6'b101101;
`endif

        // Reset mid-scan aborts; fresh scan loads new word
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("ab.busy.pre", busy, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk_zero6("abort");
        tick();
        chk("ab.held.done", done, 0);
        reset_n = 1'b1;
        w = 6'b010010;
        tick();
        chk("ab.idle.busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        pass6(w, 1'b0);
        tick();
        chk("ab.idle.done", done, 0);

        // INS=5, DWELL=1: one channel per cycle, sel never beyond 4
        w5 = 5'b11001;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        chk("d1.sel0",  sel5,  0);
        chk("d1.busy0", busy5, 1);
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk("d1.sel",  sel5,  (n < 5) ? n : 4);
            chk("d1.sv",   sv5,   1);
            chk("d1.sidx", sidx5, n - 1);
            chk("d1.sbit", sbit5, w5[n-1]);
            chk("d1.done", done5, (n == 5));
            chk("d1.busy", busy5, (n < 5));
        end
        chk("d1.cap", cap5, 5'b11001);
        tick();
        chk("d1.idle.sel",  sel5,  0);
        chk("d1.idle.busy", busy5, 0);
        chk("d1.idle.done", done5, 0);
        chk("d1.idle.sv",   sv5,   0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Drives the select input of the upstream 1-bit generic multiplexer and samples its output, one channel at a time.
- Sequences channel 0..INS-1, holds each select for DWELL cycles so the mux path settles, then samples the mux output.
- Assembles the sampled bits into a parallel capture word and signals completion.
- Sits directly downstream of the mux: sel feeds the mux select, and the mux output returns on f_in.

Parameters:
- INS, 6, number of mux channels scanned; must be >= 2 and need not be a power of 2.
- DWELL, 4, cycles each select value is held before sampling; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  scan request; sampled on rising edges.
- f_in  in  1  mux output for the current sel.
- sel  out  $clog2(INS)  mux select.
- busy  out  1  high while a scan is in progress.
- sample_valid  out  1  one-cycle pulse when a channel sample is registered.
- sample_bit  out  1  value of the latest sample.
- sample_idx  out  $clog2(INS)  channel of the latest sample.
- capture  out  INS  bit k holds the sample of channel k.
- done  out  1  one-cycle pulse when a full pass is complete.

Behaviour:
- Reset is asynchronous, active-low. On reset all outputs are 0 (sel, busy, sample_valid, sample_bit, sample_idx, capture, done); state is IDLE; dwell counter is 0.
- States are IDLE, SCAN and DONE.
- IDLE:
  - sel = 0, busy = 0.
  - start = 1 at edge E0 moves to SCAN with sel = 0, dwell counter = 0, busy = 1.
- SCAN:
  - The dwell counter increments every cycle.
  - At the edge where counter == DWELL-1:
    - capture[sel], sample_bit and sample_idx are loaded from f_in and sel.
    - sample_valid = 1 for the following cycle.
    - The counter clears.
    - If sel < INS-1, sel increments.
    - If sel == INS-1, the state goes to DONE. sel stays at INS-1 (no wrap to an invalid code).
  - Channel k is sampled at edge E0 + (k+1)*DWELL.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle, then IDLE with sel = 0.
  - done rises at edge E0 + INS*DWELL; sample_valid for the last channel is coincident with done.
- capture:
  - Bits are updated only at their own sample edge.
  - Bits are not cleared at start.
  - The word is guaranteed coherent only while done = 1 and afterwards until the next start.
- start while in SCAN is ignored; no restart and no queuing.
- start held high in DONE is not accepted in that cycle. A new scan is accepted at the first IDLE edge with start = 1, so start held high produces back-to-back passes with a 1-cycle IDLE gap.
- f_in is assumed settled within DWELL cycles. No combinational path exists from f_in to any output.
- Reset asserted mid-scan aborts immediately to the reset values. No done is generated.

Optional Feature:
- Macro: SCAN_CONTINUOUS_EN.
- Defined:
  - start is a level enable.
  - At the last channel's sample edge with start = 1: done pulses for 1 cycle while the state stays in SCAN, busy stays 1, and sel wraps to 0 on that same edge. No IDLE or DONE gap.
  - With start = 0 at that edge: normal DONE then IDLE.
  - Deasserting start mid-pass completes the current pass.
- Undefined: single-pass behaviour exactly as above.

Decomposition:
- Package scan_pkg:
  - State encoding localparams: IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2.
  - Width helper constants SEL_W = $clog2(INS) and DW_W = (DWELL > 1) ? $clog2(DWELL) : 1.
- One sub-module, dwell_counter: mod-DWELL counter with clr and a terminal-count output. It is instantiated once.
- The FSM, sel register and capture register live in the top module.

Test Plan:
- Reset with f_in = 1 and start = 1 pulsed during reset: all outputs stay 0. After release with start = 0, the block stays in IDLE.
- INS = 6, DWELL = 4, f_in driven by a mux model with w = 6'b101101:
  - start pulse at E0 → sample_valid at E0+4, 8, 12, 16, 20, 24.
  - sample_idx = 0..5 in order.
  - done at E0+24 with capture = 6'b101101.
  - busy is high for 24 cycles.
- start re-pulsed at E0+10 during a scan: no effect, done still at E0+24. start held high: the next pass begins at E0+26.
- reset_n low at E0+9, then a fresh scan with w = 6'b010010: no stale done, and capture ends as 6'b010010.
- INS = 5, DWELL = 1:
  - sel walks 0..4 one per cycle and never reaches 5–7.
  - done at E0+5.
  - w = 5'b11001 → capture = 5'b11001.
- SCAN_CONTINUOUS_EN defined, start high with w = 6'b111000:
  - done every 24 cycles with no gap and sel wraps 4 → 5 → 0.
  - start dropped at E0+30: the pass completes, done at E0+48, then IDLE.
